// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU and the blocks that drive it.
//   - ALU opcode constants (3-bit opc field)
//   - state encoding of the alu_mul_seq sequencer
package alu_pkg;

  localparam logic [2:0] OPC_NEG   = 3'b000;
  localparam logic [2:0] OPC_INC   = 3'b001;
  localparam logic [2:0] OPC_ADD   = 3'b010;
  localparam logic [2:0] OPC_ADDSH = 3'b011;
  localparam logic [2:0] OPC_AND   = 3'b100;
  localparam logic [2:0] OPC_OR    = 3'b101;
  localparam logic [2:0] OPC_MIX   = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ABS_A  = 3'd1,
    ST_ABS_B  = 3'd2,
    ST_MUL    = 3'd3,
    ST_NEG_LO = 3'd4,
    ST_NEG_HI = 3'd5,
    ST_DONE   = 3'd6
  } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Multi-cycle signed 16x16->32 multiplier that uses an external combinational
// 16-bit ALU for every arithmetic step (magnitudes, shift-add, final negate).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, a, b         request and signed operands (sampled in IDLE only)
//   busy, done          busy from the cycle after accept through DONE; done pulse
//   product             signed 32-bit product {hi,lo}
//   p_zero, p_neg       product == 0, product[31]
//   alu_opc/ina/inb/inc drive the ALU (function of state and registers only)
//   alu_w/zer/neg       ALU result and flags, captured in the same cycle
//   state               current FSM state, for observation
//
// Handshake: start is a level sampled on a rising edge while idle; once
// accepted, busy rises and start is ignored until the sequencer is back in
// IDLE. done is high for exactly one cycle, 20 cycles after the accepting
// edge, and the result holds until the next accepted start.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product,
  output logic           p_zero,
  output logic           p_neg,
  output logic [2:0]     alu_opc,
  output logic [W-1:0]   alu_ina,
  output logic [W-1:0]   alu_inb,
  output logic           alu_inc,
  input  logic [W-1:0]   alu_w,
  input  logic           alu_zer,
  input  logic           alu_neg,
  output mul_state_e     state
);

  mul_state_e state_nxt;

  logic [W-1:0] a_r, b_r;
  logic [W-1:0] m_r;   // unsigned magnitude of a (0x8000 for -32768)
  logic [W-1:0] hi, lo;
  logic [3:0]   cnt;
  logic         sgn;
  logic         z_lo;
  logic         cy;    // carry from negating lo into hi (lo negated to zero)

  // State register and datapath captures
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_r    <= '0;
      b_r    <= '0;
      m_r    <= '0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      sgn    <= 1'b0;
      z_lo   <= 1'b0;
      cy     <= 1'b0;
      p_zero <= 1'b0;
      p_neg  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_r    <= a;
            b_r    <= b;
            sgn    <= a[W-1] ^ b[W-1];
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            p_zero <= 1'b0;
            p_neg  <= 1'b0;
          end
        end
        ST_ABS_A: m_r <= alu_w;
        ST_ABS_B: lo  <= alu_w;
        ST_MUL: begin
          // Shift-add: the sum re-enters the top and the pair shifts right.
          // hi stays below 2^15 before each add, so the 16-bit sum is exact.
          {hi, lo} <= {alu_w, lo} >> 1;
          cnt      <= cnt + 4'd1;
        end
        ST_NEG_LO: begin
          lo   <= alu_w;
          z_lo <= alu_zer;
          cy   <= sgn & alu_zer;
        end
        ST_NEG_HI: begin
          hi     <= alu_w;
          p_zero <= z_lo & alu_zer;
          p_neg  <= alu_neg;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_ABS_A;
      ST_ABS_A:  state_nxt = ST_ABS_B;
      ST_ABS_B:  state_nxt = ST_MUL;
      ST_MUL:    if (cnt == 4'd15) state_nxt = ST_NEG_LO;
      ST_NEG_LO: state_nxt = ST_NEG_HI;
      ST_NEG_HI: state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: ALU drive depends only on state and registers, never on start
  always_comb begin
    alu_opc = OPC_ADDSH;
    alu_ina = '0;
    alu_inb = '0;
    alu_inc = 1'b0;
    case (state)
      ST_ABS_A: begin
        alu_ina = a_r;
        alu_opc = a_r[W-1] ? OPC_NEG : OPC_ADDSH;
      end
      ST_ABS_B: begin
        alu_ina = b_r;
        alu_opc = b_r[W-1] ? OPC_NEG : OPC_ADDSH;
      end
      ST_MUL: begin
        alu_opc = OPC_ADD;
        alu_ina = hi;
        alu_inb = lo[0] ? m_r : '0;
      end
      ST_NEG_LO: begin
        alu_ina = lo;
        alu_opc = sgn ? OPC_NEG : OPC_ADDSH;
      end
      ST_NEG_HI: begin
        if (sgn) begin
          // Two's complement of the high word: ~hi plus the carry out of lo
          alu_opc = OPC_ADD;
          alu_ina = ~hi;
          alu_inc = cy;
        end else begin
          alu_ina = hi;
        end
      end
      default: ;
    endcase
  end

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign product = {hi, lo};

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;
  import alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, p_zero, p_neg;
  logic [31:0] product;
  logic [2:0]  alu_opc;
  logic [15:0] alu_ina, alu_inb, alu_w;
  logic        alu_inc, alu_zer, alu_neg;
  mul_state_e  state;

  alu_mul_seq #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product), .p_zero(p_zero), .p_neg(p_neg),
    .alu_opc(alu_opc), .alu_ina(alu_ina), .alu_inb(alu_inb), .alu_inc(alu_inc),
    .alu_w(alu_w), .alu_zer(alu_zer), .alu_neg(alu_neg), .state(state)
  );

  // Behavioural combinational ALU the sequencer drives
  always_comb begin
    alu_w = '0;
    case (alu_opc)
      3'b000:  alu_w = 16'd0 - alu_ina;
      3'b001:  alu_w = alu_ina + 16'd1;
      3'b010:  alu_w = alu_ina + alu_inb + {15'd0, alu_inc};
      3'b011:  alu_w = alu_ina + (alu_inb << 1) + {15'd0, alu_inc};
      3'b100:  alu_w = alu_ina & alu_inb;
      3'b101:  alu_w = alu_ina | alu_inb;
      3'b110:  alu_w = alu_ina ^ alu_inb;
      default: alu_w = '0;
    endcase
  end
  assign alu_zer = (alu_w == 16'd0);
  assign alu_neg = alu_w[15];

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Higher-level reference: plain signed integer multiply
  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    int px, py;
    px = int'($signed(x));
    py = int'($signed(y));
    return 32'(px * py);
  endfunction

  // ---------------- driver tasks ----------------
  // Issue one operation and wait (bounded) for done; returns at the negedge
  // of the done cycle.
  task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b,
                        output int lat, output logic [31:0] prod,
                        output logic z, output logic n, output logic bsy);
    @(negedge clk);
    a = op_a; b = op_b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    prod = product; z = p_zero; n = p_neg; bsy = busy;
  endtask

  task automatic check_op(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                          input logic [31:0] exp_p);
    int lat; logic [31:0] prod; logic z, n, bsy;
    run_op(op_a, op_b, lat, prod, z, n, bsy);
    check({tag, " latency"}, 64'(lat), 64'd20);
    check({tag, " product"}, 64'(prod), 64'(exp_p));
    check({tag, " p_zero"}, 64'(z), 64'(exp_p == 32'd0));
    check({tag, " p_neg"}, 64'(n), 64'(exp_p[31]));
    check({tag, " busy@done"}, 64'(bsy), 64'd1);
    @(posedge clk); @(negedge clk);
    check({tag, " done drop"}, 64'({busy, done}), 64'd0);
  endtask

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic [31:0] vp;
  } vec_t;

  initial begin
    vec_t vecs[$];
    int lat, dones;
    logic [31:0] prod, got_p;
    logic z, n, bsy;
    logic [15:0] ra, rb;

    vecs.push_back('{16'd3,      16'd5,      32'h0000000F});
    vecs.push_back('{-16'sd7,    16'd6,      32'hFFFFFFD6});
    vecs.push_back('{16'h8000,   16'h8000,   32'h40000000});
    vecs.push_back('{16'd0,      16'hFFFF,   32'h00000000});
    vecs.push_back('{16'h8000,   16'd1,      32'hFFFF8000});
    vecs.push_back('{16'h7FFF,   16'h7FFF,   32'h3FFF0001});
    vecs.push_back('{16'h8000,   16'h7FFF,   32'hC0008000});
    vecs.push_back('{16'hFFFF,   16'hFFFF,   32'h00000001});
    vecs.push_back('{16'd1234,   16'd0,      32'h00000000});

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy/done", 64'({busy, done}), 64'd0);
    check("reset product", 64'(product), 64'd0);
    check("reset flags", 64'({p_zero, p_neg}), 64'd0);
    check("reset state", 64'(state), 64'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1; a = 16'h1234; b = 16'h5678;
    #1;
    check("idle alu drive", 64'({alu_opc, alu_ina, alu_inb, alu_inc}),
          64'({3'b011, 16'd0, 16'd0, 1'b0}));
    start = 1'b0;

    // ---- table-driven vectors ----
    foreach (vecs[i]) check_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vp);

    // ---- start while busy is ignored ----
    @(negedge clk);
    a = 16'd100; b = 16'd200; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    a = 16'd7; b = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0; got_p = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) begin dones++; got_p = product; end
    end
    check("busy-start done count", 64'(dones), 64'd1);
    check("busy-start product", 64'(got_p), 64'd20000);

    // ---- start held through DONE is only taken in IDLE ----
    run_op(16'd5, 16'd6, lat, prod, z, n, bsy);
    check("pre-hold product", 64'(prod), 64'd30);
    a = 16'd9; b = 16'd9; start = 1'b1;
    @(posedge clk); @(negedge clk);
    check("start in DONE ignored", 64'(busy), 64'd0);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    check("start in IDLE taken", 64'(busy), 64'd1);
    lat = 0;
    while (!done && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
    check("held-start latency", 64'(lat), 64'd20);
    check("held-start product", 64'(product), 64'd81);
    @(posedge clk); @(negedge clk);

    // ---- reset in the middle of MUL ----
    a = 16'd1234; b = 16'hFFFD; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("mid-op in MUL", 64'(state), 64'(ST_MUL));
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    check("mid-rst busy/done", 64'({busy, done}), 64'd0);
    check("mid-rst product", 64'(product), 64'd0);
    check("mid-rst flags", 64'({p_zero, p_neg}), 64'd0);
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("mid-rst no activity", 64'(dones), 64'd0);
    check_op("post-rst", 16'd2, 16'hFFFE, 32'hFFFFFFFC);

    // ---- randomized against the reference model ----
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 16'($urandom_range(0, 15));
        1: ra = 16'h8000 | 16'($urandom_range(0, 3));
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: rb = 16'hFFFF - 16'($urandom_range(0, 3));
        1: rb = 16'h7FFF - 16'($urandom_range(0, 3));
        default: rb = 16'($urandom);
      endcase
      check_op($sformatf("rand%0d a=%0h b=%0h", i, ra, rb), ra, rb, ref_mul(ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle signed 16×16→32 multiplier sequencer that acts as the initiator for the team's combinational 16-bit ALU. The ALU performs every arithmetic step; this block only issues opcodes and operands, captures results, and sequences them. It takes operands through a start/busy/done handshake. It sits between a command source and the ALU ports (`opc`, `ina`, `inb`, `inc`, `w`, `zer`, `neg`).

## Interface
- `W`, 16: operand width, fixed to ALU width. Any other value is unsupported.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request. Sampled only in IDLE.
- `a`, `b` in 16: signed operands, sampled on the start edge.
- `busy` out 1: high from the cycle after start is accepted through the DONE cycle.
- `done` out 1: one-cycle pulse; `product`, `p_zero` and `p_neg` are valid in that cycle and hold until the next start.
- `product` out 32: signed product.
- `p_zero`, `p_neg` out 1: product == 0; product[31].
- `alu_opc` out 3, `alu_ina` out 16, `alu_inb` out 16, `alu_inc` out 1: drive the ALU.
- `alu_w` in 16, `alu_zer` in 1, `alu_neg` in 1: ALU result and flags, used combinationally in the same cycle.

## Operation
- States: IDLE → ABS_A → ABS_B → MUL (16 iterations) → NEG_LO → NEG_HI → DONE → IDLE.
- IDLE: the ALU is driven with opc=011, ina=0, inb=0, inc=0 (result 0).
- If `start`=1 in IDLE:
  - Latch a, b.
  - Latch sgn = a[15]^b[15].
  - Clear hi, lo and the 4-bit counter.
- ABS_A:
  - If a<0: opc=000, ina=a (two's negate).
  - Else: opc=011, ina=a, inb=0, inc=0 (pass-through).
  - Capture `alu_w` into M, an unsigned magnitude. −32768 gives M=0x8000.
- ABS_B: same as ABS_A for b; capture `alu_w` into lo.
- MUL, each cycle:
  - Drive opc=010, ina=hi, inb = lo[0] ? M : 0, inc=0.
  - Update {hi,lo} <= {alu_w,lo} >> 1, zero-filled.
  - Counter increments; exit after count 15.
  - Invariant: hi < 2^15 before each add, so no carry is lost.
- NEG_LO:
  - If sgn: opc=000, ina=lo.
  - Else: pass-through.
  - Capture lo <= alu_w.
  - Latch z_lo = alu_zer and cy = sgn & alu_zer.
- NEG_HI:
  - If sgn: opc=010, ina=~hi, inb=0, inc=cy.
  - Else: pass-through of hi.
  - Capture hi <= alu_w.
  - p_zero <= z_lo & alu_zer; p_neg <= alu_neg.
- DONE: done=1, busy=1. The next edge returns to IDLE.
- `start` while busy is ignored, with no queuing.
- `start` held high continuously starts a new operation in every IDLE cycle.
- Reset, including mid-operation, forces:
  - State to IDLE.
  - busy=0, done=0, product=0, p_zero=0, p_neg=0.
  - hi, lo, M and the counter to 0.

## Timing
- Edge 0 samples start. busy is high after edge 0.
- Edges 1–20 execute ABS_A, ABS_B, MUL×16, NEG_LO and NEG_HI.
- done is high in the cycle after edge 20. busy and done drop after edge 21.
- Fixed latency of 20 cycles from start edge to done, independent of operand values and signs.
- Minimum issue interval: 22 cycles (start is accepted in the IDLE cycle following DONE).
- ALU outputs are a combinational function of state and registers only, with no dependence on `start`.
- The ALU path is combinational: the critical path is register → ALU → capture within one cycle.

## Structure
- Shared package `alu_pkg` holds:
  - Opcode constants: OPC_NEG=000, OPC_INC=001, OPC_ADD=010, OPC_ADDSH=011, OPC_AND=100, OPC_OR=101, OPC_MIX=110.
  - The state enum for this block.
- Single module, no sub-modules. The ALU is instantiated by the enclosing level or bench, never inside this block.

## Test plan
- a=3, b=5, start: done exactly 20 cycles after the start edge; product=0x0000000F, p_zero=0, p_neg=0.
- a=−7, b=6: product=0xFFFFFFD6 (−42), p_neg=1.
- a=−32768, b=−32768: product=0x40000000, p_neg=0.
- a=0, b=−1: product=0, p_zero=1, p_neg=0.
- Start pulse at cycle 5 of a busy operation (a=100, b=200) is ignored: a single done, product=20000, next start accepted only after IDLE.
- rst_n low for 1 cycle at MUL iteration 8 (a=1234, b=−3): all outputs 0 after reset, no done. A new start (a=2, b=−2) then yields product=0xFFFFFFFC.
